// File: rtl/button_conditioner.sv
// Multi-channel push-button/switch conditioner: 2-flop synchroniser, stability-window
// debounce, registered press/release pulses and a per-channel toggle with clear.
module button_conditioner #(
    parameter int unsigned N_CH            = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = 19
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] btn_in,
    input  logic [N_CH-1:0] clr_toggle,
    output logic [N_CH-1:0] btn_level,
    output logic [N_CH-1:0] btn_press,
    output logic [N_CH-1:0] btn_release,
    output logic [N_CH-1:0] btn_toggle
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [N_CH-1:0]  sync1;
    logic [N_CH-1:0]  sync2;
    logic [CNT_W-1:0] cnt      [N_CH];
    logic [CNT_W-1:0] cnt_next [N_CH];
    logic [N_CH-1:0]  accept_c;
    logic [N_CH-1:0]  rise_c;
    logic [N_CH-1:0]  fall_c;

    // A channel is accepted once sync2 has differed from the level for the whole window.
    always_comb begin
        accept_c = '0;
        for (int i = 0; i < int'(N_CH); i++) begin
            cnt_next[i] = CNT_ZERO;
            if (sync2[i] != btn_level[i]) begin
                if (cnt[i] == CNT_LAST) begin
                    accept_c[i] = 1'b1;
                end else begin
                    cnt_next[i] = cnt[i] + CNT_ONE;
                end
            end
        end
        rise_c = accept_c & sync2;
        fall_c = accept_c & ~sync2;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1       <= '0;
            sync2       <= '0;
            btn_level   <= '0;
            btn_press   <= '0;
            btn_release <= '0;
            btn_toggle  <= '0;
            for (int i = 0; i < int'(N_CH); i++) begin
                cnt[i] <= CNT_ZERO;
            end
        end else begin
            sync1       <= btn_in;
            sync2       <= sync1;
            btn_level   <= btn_level ^ accept_c;
            btn_press   <= rise_c;
            btn_release <= fall_c;
            // Clear has priority over a coincident press.
            btn_toggle  <= (btn_toggle ^ rise_c) & ~clr_toggle;
            for (int i = 0; i < int'(N_CH); i++) begin
                cnt[i] <= cnt_next[i];
            end
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with a short debounce window (8 cycles).
module tb_button_conditioner;

    localparam int unsigned N_CH = 4;
    localparam int unsigned DEB  = 8;
    localparam int unsigned CW   = 4;
    localparam int          ACC  = 9;   // window index at which the accepting edge lands

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N_CH-1:0] btn_in;
    logic [N_CH-1:0] clr_toggle;
    logic [N_CH-1:0] btn_level;
    logic [N_CH-1:0] btn_press;
    logic [N_CH-1:0] btn_release;
    logic [N_CH-1:0] btn_toggle;

    int n_pass  = 0;
    int n_total = 0;

    button_conditioner #(
        .N_CH           (N_CH),
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W          (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_in     (btn_in),
        .clr_toggle (clr_toggle),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .btn_toggle (btn_toggle)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    // One active edge, then settle on the falling edge where sampling and driving happen.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    // Run n edges; press/release must equal the given masks only at index 'at', else zero.
    task automatic window(input string tag, input int n, input int at,
                          input logic [N_CH-1:0] exp_p, input logic [N_CH-1:0] exp_r);
        for (int i = 0; i < n; i++) begin
            step(1);
            check($sformatf("%s press[%0d]", tag, i), 32'(btn_press),
                  (i == at) ? 32'(exp_p) : 32'd0);
            check($sformatf("%s release[%0d]", tag, i), 32'(btn_release),
                  (i == at) ? 32'(exp_r) : 32'd0);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        btn_in     = '0;
        clr_toggle = '0;
        step(2);
        check("reset level",   32'(btn_level),   32'h0);
        check("reset press",   32'(btn_press),   32'h0);
        check("reset release", 32'(btn_release), 32'h0);
        check("reset toggle",  32'(btn_toggle),  32'h0);
        rst_n = 1'b1;
        step(2);

        // Clean press on channel 1.
        btn_in = 4'b0010;
        step(ACC);
        check("clean level before", 32'(btn_level), 32'h0);
        check("clean press before", 32'(btn_press), 32'h0);
        step(1);
        check("clean level",   32'(btn_level),   32'h2);
        check("clean press",   32'(btn_press),   32'h2);
        check("clean release", 32'(btn_release), 32'h0);
        check("clean toggle",  32'(btn_toggle),  32'h2);
        step(1);
        check("clean press gone", 32'(btn_press), 32'h0);
        check("clean level held", 32'(btn_level), 32'h2);

        // Bounce on channel 0 never reaches the window.
        btn_in = 4'b0011; window("bounce h1", 5, -1, '0, '0);
        btn_in = 4'b0010; window("bounce l1", 2, -1, '0, '0);
        btn_in = 4'b0011; window("bounce h2", 5, -1, '0, '0);
        btn_in = 4'b0010; window("bounce l2", 12, -1, '0, '0);
        check("bounce level", 32'(btn_level), 32'h2);
        btn_in = 4'b0011; window("bounce final", 12, ACC, 4'b0001, '0);
        check("bounce level after", 32'(btn_level),  32'h3);
        check("bounce toggle",      32'(btn_toggle), 32'h3);

        // Channel 2: press, release, press again.
        btn_in = 4'b0111; window("ch2 press1", 12, ACC, 4'b0100, '0);
        check("ch2 toggle1", 32'(btn_toggle), 32'h7);
        btn_in = 4'b0011; window("ch2 release", 12, ACC, '0, 4'b0100);
        check("ch2 toggle kept", 32'(btn_toggle), 32'h7);
        check("ch2 level low",   32'(btn_level),  32'h3);
        btn_in = 4'b0111; window("ch2 press2", 12, ACC, 4'b0100, '0);
        check("ch2 toggle2", 32'(btn_toggle), 32'h3);

        // Clear with no press, then clear coincident with a press.
        clr_toggle = 4'b0010;
        step(1);
        clr_toggle = '0;
        check("clr idle toggle", 32'(btn_toggle), 32'h1);
        btn_in = 4'b0101; window("ch1 release", 12, ACC, '0, 4'b0010);
        btn_in = 4'b0111;
        step(ACC);
        check("clr press before", 32'(btn_press), 32'h0);
        clr_toggle = 4'b0010;
        step(1);
        clr_toggle = '0;
        check("clr press pulse",  32'(btn_press),  32'h2);
        check("clr press toggle", 32'(btn_toggle), 32'h1);
        step(1);
        check("clr after toggle", 32'(btn_toggle), 32'h1);
        check("clr after press",  32'(btn_press),  32'h0);

        // Async reset partway through channel 3's window (count 5 after 7 edges).
        btn_in = 4'b1000;
        step(7);
        check("pre-reset level",  32'(btn_level),  32'h7);
        check("pre-reset toggle", 32'(btn_toggle), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("async level",   32'(btn_level),   32'h0);
        check("async toggle",  32'(btn_toggle),  32'h0);
        check("async press",   32'(btn_press),   32'h0);
        check("async release", 32'(btn_release), 32'h0);
        @(negedge clk);
        step(1);
        rst_n = 1'b1;
        window("post-reset", 12, ACC, 4'b1000, '0);
        check("post-reset toggle", 32'(btn_toggle), 32'h8);

        // All channels rise together.
        btn_in = 4'b0000; window("par release", 12, ACC, '0, 4'b1000);
        btn_in = 4'b1111; window("par press", 12, ACC, 4'b1111, '0);
        check("par level",  32'(btn_level),  32'hF);
        check("par toggle", 32'(btn_toggle), 32'h7);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
